disp_src_arbiter: RTL
=====================

Name: disp_src_arbiter

Overview:
Shares the single 8-digit multiplexed 7-segment display between three requesters: the running chronometer time, a frozen lap time, and a message/alert source. It selects which digit vector and dot mask drive the display controller's value/dot inputs, holds a lap snapshot on screen for a programmable number of time-base ticks, and lets messages pre-empt both. It sits between the chronometer counter/control logic and the display controller.

Parameters:
HOLD_TICKS, 200, number of tick strobes a lap snapshot stays displayed (200 x 10 ms = 2 s); legal range 1..65535.
HW, $clog2(HOLD_TICKS+1), width of the hold counter (derived, not overridden).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
tick  input  1  one-cycle time-base strobe (10 ms)
run_value  input  [7:0][3:0]  live chronometer digits
run_dot  input  8  live dot mask
lap_req  input  1  one-cycle pulse: capture and show lap
lap_value  input  [7:0][3:0]  lap digits, sampled only when lap_req=1
lap_dot  input  8  lap dot mask, sampled only when lap_req=1
msg_req  input  1  level: message owns display while high
msg_value  input  [7:0][3:0]  message digits (live while msg_req=1)
msg_dot  input  8  message dot mask
value  output  [7:0][3:0]  digits to display controller (registered)
dot  output  8  dot mask to display controller (registered)
src  output  2  current owner, src_e encoding (registered)
lap_busy  output  1  lap hold pending (hold counter non-zero)

Behaviour:
- Reset (async assert, sync release): value=all 4'h0, dot=8'h00, src=SRC_RUN, snapshot regs=0, hold counter=0, lap_busy=0. Reset mid-hold aborts the lap; no pending state survives.
- Priority: MSG > LAP > RUN. Owner each cycle: MSG if msg_req; else LAP if hold counter !=0 (after this cycle's updates); else RUN.
- All outputs registered; latency 1 cycle from any input change to value/dot/src.
- lap_req at cycle N: lap_value/lap_dot captured into snapshot; hold counter loaded with HOLD_TICKS. At N+1 (msg_req low): value=lap_value sampled at N, src=SRC_LAP. Output mux uses lap inputs directly in cycle N so no extra cycle.
- lap_req while already LAP: recapture, reload counter (restart hold).
- tick while in LAP and msg_req low: counter decrements. Tick that takes counter 1->0: outputs return to live run_value on the following edge (src=SRC_RUN). With HOLD_TICKS=3, lap visible through 3rd tick; run visible the cycle after it.
- tick coincident with lap_req: load wins, tick ignored.
- msg_req high: counter paused (ticks ignored), snapshot retained. msg_req falls: LAP resumes with remaining count if non-zero, else RUN.
- lap_req while msg_req high: captured and loaded; shown after message ends with full HOLD_TICKS remaining.
- RUN and MSG pass live inputs every cycle (running digits tick visibly).
- lap_busy = (hold counter != 0), combinational from the counter register.
- Counter never underflows: decrement only when non-zero.
- Assertion: HOLD_TICKS >= 1 (elaboration check); src never takes value 2'd3.

Decomposition:
- Shared package cron_pkg: typedef digits_t = logic [7:0][3:0]; enum src_e {SRC_RUN=2'd0, SRC_LAP=2'd1, SRC_MSG=2'd2}; constant TICK_PERIOD_MS=10.
- One sub-module: disp_hold_timer (load, tick, pause -> count, busy), parameterised by HOLD_TICKS; output mux/registers stay in the top.

Test Plan:
- Reset release, run_value=12345678, dot=8'h14 -> after 1 cycle value=12345678, dot=8'h14, src=RUN, lap_busy=0.
- HOLD_TICKS=3, lap_req with lap_value=00012345, run_value keeps incrementing -> value fixed 00012345 through 3rd tick; cycle after 3rd tick value=live run_value, src=RUN.
- lap_req at hold count 1 with new lap_value=00099999 -> value switches next cycle, hold restarts to 3 ticks.
- During lap (2 ticks left) assert msg_req 50 cycles with 5 ticks, msg_value=EEEEEEEE -> value=EEEEEEEE, src=MSG; on release lap resumes, reverts after exactly 2 more ticks.
- tick and lap_req same cycle, HOLD_TICKS=3 -> counter=3 (not 2); lap shown for 3 further ticks.
- Assert rst asynchronously mid-hold (no clk edge) -> value=0, src=RUN, lap_busy=0 immediately; after release no lap reappears.

Source files
------------

// File: rtl/cron_pkg.sv
// Shared types for the chronometer display path.
// Digit vectors, display-owner encoding and time-base constants.
package cron_pkg;

  typedef logic [7:0][3:0] digits_t;

  typedef enum logic [1:0] {
    SRC_RUN = 2'd0,
    SRC_LAP = 2'd1,
    SRC_MSG = 2'd2
  } src_e;

  localparam int TICK_PERIOD_MS = 10;

endpackage

// File: rtl/disp_hold_timer.sv
// Lap hold counter: loads HOLD_TICKS, counts ticks down to zero.
// Pause freezes the count; load always wins over a same-cycle tick.
module disp_hold_timer #(
  parameter int HOLD_TICKS = 200,
  localparam int HW = $clog2(HOLD_TICKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_tick,
  input  logic          i_pause,
  output logic [HW-1:0] o_count_nxt,
  output logic          o_busy
);

  logic [HW-1:0] r_count;
  logic [HW-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (i_load) begin
      w_count_nxt = HW'(HOLD_TICKS);
    end else if (i_tick && !i_pause && r_count != '0) begin
      w_count_nxt = r_count - HW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count_nxt = w_count_nxt;
  assign o_busy      = (r_count != '0);

endmodule

// File: rtl/disp_src_arbiter.sv
// Picks run / lap / message digits for the 7-segment display.
// Priority MSG > LAP > RUN; all display outputs registered.
module disp_src_arbiter
  import cron_pkg::*;
#(
  parameter int HOLD_TICKS = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [7:0][3:0] run_value,
  input  logic [7:0]      run_dot,
  input  logic            lap_req,
  input  logic [7:0][3:0] lap_value,
  input  logic [7:0]      lap_dot,
  input  logic            msg_req,
  input  logic [7:0][3:0] msg_value,
  input  logic [7:0]      msg_dot,
  output logic [7:0][3:0] value,
  output logic [7:0]      dot,
  output logic [1:0]      src,
  output logic            lap_busy
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  if (HOLD_TICKS < 1 || HOLD_TICKS > 65535) begin : g_bad_hold
    $error("disp_src_arbiter: HOLD_TICKS out of range 1..65535");
  end

  logic [HW-1:0] w_cnt_nxt;
  logic          w_busy;
  src_e          w_src;
  digits_t       w_value;
  logic [7:0]    w_dot;

  digits_t       r_lap_value;
  logic [7:0]    r_lap_dot;
  digits_t       r_value;
  logic [7:0]    r_dot;
  src_e          r_src;

  disp_hold_timer #(
    .HOLD_TICKS (HOLD_TICKS)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .i_load      (lap_req),
    .i_tick      (tick),
    .i_pause     (msg_req),
    .o_count_nxt (w_cnt_nxt),
    .o_busy      (w_busy)
  );

  always_comb begin
    w_src = SRC_RUN;
    if (msg_req) begin
      w_src = SRC_MSG;
    end else if (w_cnt_nxt != '0) begin
      w_src = SRC_LAP;
    end
  end

  // A lap request is shown straight from its inputs to avoid a bubble.
  always_comb begin
    w_value = run_value;
    w_dot   = run_dot;
    unique case (w_src)
      SRC_MSG: begin
        w_value = msg_value;
        w_dot   = msg_dot;
      end
      SRC_LAP: begin
        w_value = lap_req ? lap_value : r_lap_value;
        w_dot   = lap_req ? lap_dot   : r_lap_dot;
      end
      default: begin
        w_value = run_value;
        w_dot   = run_dot;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_value <= '0;
      r_lap_dot   <= '0;
    end else if (lap_req) begin
      r_lap_value <= lap_value;
      r_lap_dot   <= lap_dot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_dot   <= '0;
      r_src   <= SRC_RUN;
    end else begin
      r_value <= w_value;
      r_dot   <= w_dot;
      r_src   <= w_src;
    end
  end

  assign value    = r_value;
  assign dot      = r_dot;
  assign src      = r_src;
  assign lap_busy = w_busy;

  a_src_legal: assert property (
    @(posedge clk) disable iff (rst) r_src != 2'd3
  );

endmodule
